// File: rtl/galaga_pkg.sv
// Shared screen geometry and the enum types used by the player-ship input stage.
package galaga_pkg;

    localparam int SCREEN_W = 640;
    localparam int SHIP_W   = 32;
    localparam int X_W      = 10;

    typedef enum logic [1:0] {IDLE, SLOW, FAST} ramp_state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    // Pressing both buttons cancels out rather than favouring one side.
    function automatic dir_t decode_dir(input logic left_lvl, input logic right_lvl);
        if (left_lvl && !right_lvl) begin
            return DIR_LEFT;
        end else if (right_lvl && !left_lvl) begin
            return DIR_RIGHT;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Button/tick inputs and ship position/status outputs of the player control stage.
interface player_ctrl_if;
    import galaga_pkg::*;

    logic           left;
    logic           right;
    logic           frame_tick;
    logic [X_W-1:0] ship_x;
    logic           left_db;
    logic           right_db;
    logic           fast;

    modport master (
        output left, right, frame_tick,
        input  ship_x, left_db, right_db, fast
    );

    modport slave (
        input  left, right, frame_tick,
        output ship_x, left_db, right_db, fast
    );

endinterface

// File: rtl/player_ctrl_debouncer.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/player_ctrl.sv
// Debounces the left/right buttons and moves the ship once per frame with a hold-to-accelerate ramp.
module player_ctrl
    import galaga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 608,
    parameter int X_RESET         = 304,
    parameter int STEP_SLOW       = 2,
    parameter int STEP_FAST       = 6,
    parameter int HOLD_FRAMES     = 30
) (
    input  logic         clk,
    input  logic         reset,
    player_ctrl_if.slave bus
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [X_W:0] XMIN_S = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(X_MAX);

    logic [1:0] btn_raw;
    logic [1:0] btn_db;

    assign btn_raw = {bus.right, bus.left};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (btn_raw[gi]),
            .dout  (btn_db[gi])
        );
    end

    ramp_state_t         state_q, state_d;
    dir_t                dir, dir_q, dir_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [X_W-1:0]      x_q, x_d;
    logic                fast_q;
    logic signed [X_W:0] step;
    logic signed [X_W:0] x_sum;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        x_d     = x_q;
        dir     = decode_dir(btn_db[0], btn_db[1]);
        step    = (state_q == FAST) ? (X_W+1)'(STEP_FAST) : (X_W+1)'(STEP_SLOW);
        x_sum   = $signed({1'b0, x_q});

        if (bus.frame_tick) begin
            dir_d = dir;
            unique case (state_q)
                IDLE: begin
                    if (dir != DIR_NONE) begin
                        state_d = SLOW;
                        hold_d  = HW'(1);
                    end
                end
                SLOW: begin
                    if (dir == DIR_NONE) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (dir != dir_q) begin
                        hold_d  = HW'(1);
                    end else if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                        state_d = FAST;
                    end else begin
                        hold_d  = hold_q + HW'(1);
                    end
                end
                default: begin
                    if (dir == DIR_NONE) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (dir != dir_q) begin
                        state_d = SLOW;
                        hold_d  = HW'(1);
                    end
                end
            endcase

            // 11-bit signed sum so a step past zero clamps instead of wrapping.
            if (dir == DIR_LEFT) begin
                x_sum = $signed({1'b0, x_q}) - step;
                x_d   = (x_sum < XMIN_S) ? X_W'(X_MIN) : x_sum[X_W-1:0];
            end else if (dir == DIR_RIGHT) begin
                x_sum = $signed({1'b0, x_q}) + step;
                x_d   = (x_sum > XMAX_S) ? X_W'(X_MAX) : x_sum[X_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dir_q   <= DIR_NONE;
            x_q     <= X_W'(X_RESET);
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            fast_q  <= (state_d == FAST);
        end
    end

    assign bus.ship_x   = x_q;
    assign bus.left_db  = btn_db[0];
    assign bus.right_db = btn_db[1];
    assign bus.fast     = fast_q;

endmodule
